lift_scheduler: RTL



---
 rtl/lift_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lift_scheduler.sv
// SCAN-policy lift car scheduler: latches floor calls, steps the car one floor per
// travel interval and runs a timed door dwell. Define LIFT_DOOR_REOPEN_EN to let a
// same-floor call during the dwell restart the door timer.
module lift_scheduler #(
  parameter int NFLOORS    = 4,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] req,
  output logic [2:0]         floor,
  output logic               dir,
  output logic               moving,
  output logic               door_open,
  output logic               arrive,
  output logic [NFLOORS-1:0] pending
);
  localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

  state_e             state_q, state_d;
  logic [2:0]         floor_q, floor_d, nxt_floor;
  logic               dir_q, dir_d, arrive_q, arrive_d, at_end;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [NFLOORS-1:0] pending_q, pending_d, pend_in, clear_mask;
  logic [NFLOORS-1:0] cur_oh, nxt_oh, above_m, below_m, beyond_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      arrive_q  <= 1'b0;
      tmr_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      arrive_q  <= arrive_d;
      tmr_q     <= tmr_d;
      pending_q <= pending_d;
    end
  end

  // Floor masks relative to the current floor and to the floor the car steps into.
  always_comb begin
    nxt_floor = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
    at_end    = dir_q ? (floor_q == 3'(NFLOORS-1)) : (floor_q == 3'd0);
    pend_in   = pending_q | req;
    for (int i = 0; i < NFLOORS; i++) begin
      cur_oh[i]   = (floor_q == 3'(i));
      nxt_oh[i]   = (nxt_floor == 3'(i));
      above_m[i]  = (3'(i) > floor_q);
      below_m[i]  = (3'(i) < floor_q);
      beyond_m[i] = dir_q ? (3'(i) > nxt_floor) : (3'(i) < nxt_floor);
    end
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    arrive_d   = 1'b0;
    tmr_d      = tmr_q;
    clear_mask = '0;
    case (state_q)
      S_IDLE: begin
        if (|(pending_q & cur_oh)) begin
          state_d    = S_DOOR;
          clear_mask = cur_oh;
          tmr_d      = TW'(DOOR_CYC - 1);
        end else if (|pending_q) begin
          state_d = S_MOVE;
          tmr_d   = TW'(TRAVEL_CYC - 1);
          dir_d   = dir_q ? (|(pending_q & above_m)) : !(|(pending_q & below_m));
          if (floor_q == 3'd0)                 dir_d = 1'b1;
          else if (floor_q == 3'(NFLOORS-1))   dir_d = 1'b0;
        end
      end
      S_MOVE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (at_end) begin
          state_d = S_IDLE;
        end else begin
          floor_d  = nxt_floor;
          arrive_d = 1'b1;
          if (|(pend_in & nxt_oh)) begin
            state_d    = S_DOOR;
            clear_mask = nxt_oh;
            tmr_d      = TW'(DOOR_CYC - 1);
          end else if (|(pend_in & beyond_m)) begin
            tmr_d = TW'(TRAVEL_CYC - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        // Same-floor calls are absorbed while the door is open.
        clear_mask = cur_oh;
`ifdef LIFT_DOOR_REOPEN_EN
        if (|(req & cur_oh))        tmr_d   = TW'(DOOR_CYC - 1);
        else if (tmr_q == '0)       state_d = S_IDLE;
        else                        tmr_d   = tmr_q - TW'(1);
`else
        if (tmr_q == '0)            state_d = S_IDLE;
        else                        tmr_d   = tmr_q - TW'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = pend_in & ~clear_mask;
  end

  always_comb begin
    moving    = (state_q == S_MOVE);
    door_open = (state_q == S_DOOR);
    floor     = floor_q;
    dir       = dir_q;
    arrive    = arrive_q;
    pending   = pending_q;
  end
endmodule
